// File: rtl/meas_sched_pkg.sv
// Shared types and constants for the measurement scheduler.
// Report modes select which word groups the serial controller sends.
package meas_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        MEASURE,
        REPORT_REQ,
        REPORT_WAIT,
        HOLD
    } state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_FREQ = 2'b10;
    localparam logic [1:0] MODE_TIME = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam logic [7:0] TIMEOUT_SAT = 8'hFF;

    function automatic logic mode_valid(input logic [1:0] m);
        return (m == MODE_FREQ) || (m == MODE_TIME) || (m == MODE_BOTH);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == TIMEOUT_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/meas_scheduler_ms_ticker.sv
// Millisecond prescaler: one-clock tick every TICK_DIV clocks.
// A synchronous clear re-phases the tick to the caller's event.
module ms_ticker #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/meas_scheduler.sv
// Periodic measure-then-report sequencer with watchdog and overrun flag.
// Period and watchdog timebases are re-phased at every ARM.
module meas_scheduler
    import meas_sched_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int PERIOD_MS  = 1000,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] mode_sel,
    input  logic       clr_ovr,
    output logic       meas_start,
    input  logic       meas_done,
    output logic       rpt_start,
    input  logic       rpt_busy,
    output logic [1:0] rpt_mode,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] timeout_cnt
);

    localparam int PW = $clog2(PERIOD_MS + 1);
    localparam int WW = $clog2(TIMEOUT_MS + 1);
    localparam logic [PW-1:0] PER    = PW'(PERIOD_MS);
    localparam logic [PW-1:0] PER_M1 = PW'(PERIOD_MS - 1);
    localparam logic [WW-1:0] WD_M1  = WW'(TIMEOUT_MS - 1);

    state_t        state;
    logic [PW-1:0] period_cnt;
    logic [WW-1:0] wd_cnt;
    logic          first_hold;
    logic          tick;
    logic          run_ok;
    logic          elapsed;
    logic          period_due;
    logic          wd_expire;
    logic          go_arm;

    ms_ticker #(
        .TICK_DIV(TICK_DIV)
    ) u_ticker (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (go_arm),
        .tick (tick)
    );

    assign run_ok    = enable && mode_valid(mode_sel);
    assign elapsed   = (period_cnt == PER);
    // Look one tick ahead so ARM lands exactly PERIOD_MS*TICK_DIV clocks apart
    assign period_due = elapsed || (tick && (period_cnt == PER_M1));
    assign wd_expire = tick && (wd_cnt == WD_M1);
    assign go_arm    = run_ok &&
                       ((state == IDLE) || ((state == HOLD) && period_due));

    assign meas_start = (state == ARM);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
            wd_cnt     <= '0;
        end else if (go_arm) begin
            period_cnt <= '0;
            wd_cnt     <= '0;
        end else begin
            if (tick && !elapsed) begin
                period_cnt <= period_cnt + PW'(1);
            end
            if (tick && (state == MEASURE)) begin
                wd_cnt <= wd_cnt + WW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rpt_start   <= 1'b0;
            rpt_mode    <= MODE_NONE;
            overrun     <= 1'b0;
            timeout_cnt <= '0;
            first_hold  <= 1'b0;
        end else begin
            if (clr_ovr) begin
                overrun <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (go_arm) begin
                        state    <= ARM;
                        rpt_mode <= mode_sel;
                    end
                end
                ARM: begin
                    state <= MEASURE;
                end
                MEASURE: begin
                    if (meas_done) begin
                        state     <= REPORT_REQ;
                        rpt_start <= 1'b1;
                    end else if (wd_expire) begin
                        state       <= HOLD;
                        first_hold  <= 1'b1;
                        timeout_cnt <= sat_inc(timeout_cnt);
                    end
                end
                REPORT_REQ: begin
                    if (rpt_busy) begin
                        state     <= REPORT_WAIT;
                        rpt_start <= 1'b0;
                    end
                end
                REPORT_WAIT: begin
                    if (!rpt_busy) begin
                        state      <= HOLD;
                        first_hold <= 1'b1;
                    end
                end
                HOLD: begin
                    first_hold <= 1'b0;
                    // Set after the clear above, so a coincident overrun wins
                    if (first_hold && elapsed) begin
                        overrun <= 1'b1;
                    end
                    if (!run_ok) begin
                        state <= IDLE;
                    end else if (go_arm) begin
                        state    <= ARM;
                        rpt_mode <= mode_sel;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_meas_scheduler.sv
// Randomised scenario bench for meas_scheduler against a timing model.
// Expected event times are derived from period, watchdog and handshake rules.
module tb_meas_scheduler;

    localparam int TD  = 4;
    localparam int PMS = 10;
    localparam int TMS = 5;
    localparam int P    = PMS * TD;
    localparam int TO_H = TMS * TD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode_sel = 2'b00;
    logic       clr_ovr = 1'b0;
    logic       meas_done = 1'b0;
    logic       rpt_busy = 1'b0;
    logic       meas_start;
    logic       rpt_start;
    logic [1:0] rpt_mode;
    logic       busy;
    logic       overrun;
    logic [7:0] timeout_cnt;

    int         vectors = 0;
    int         miscompares = 0;
    int         m_to = 0;
    bit         m_ov = 1'b0;
    logic [1:0] exp_mode = 2'b00;

    always #5 clk = ~clk;

    meas_scheduler #(
        .TICK_DIV  (TD),
        .PERIOD_MS (PMS),
        .TIMEOUT_MS(TMS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode_sel   (mode_sel),
        .clr_ovr    (clr_ovr),
        .meas_start (meas_start),
        .meas_done  (meas_done),
        .rpt_start  (rpt_start),
        .rpt_busy   (rpt_busy),
        .rpt_mode   (rpt_mode),
        .busy       (busy),
        .overrun    (overrun),
        .timeout_cnt(timeout_cnt)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // One ARM-to-ARM cycle starting at the ARM clock (rel 0).
    // d: done offset (outside 1..TO_H-1 means watchdog expiry);
    // bd/bl: busy delay after rpt_start and busy length;
    // mode/enable switch to m_next/en_next from rel 2; clr_ovr at clr_at.
    task automatic run_cycle(input int d, input int bd, input int bl,
                             input logic [1:0] m_next, input logic en_next,
                             input int clr_at);
        bit         tmo;
        bit         late;
        bit         stop;
        int         h;
        int         nxt;
        int         last;
        logic [2:0] exp_ctl;
        logic [1:0] want_mode;
        tmo  = (d < 1) || (d >= TO_H);
        h    = tmo ? TO_H : d + 2 + bd + bl;
        late = (h + 1 > P);
        stop = !en_next || (m_next == 2'b00);
        nxt  = late ? h + 1 : P;
        last = stop ? h + 1 : nxt;
        for (int rel = 1; rel <= last; rel++) begin
            step();
            exp_ctl[2] = !stop && (rel == nxt);
            exp_ctl[1] = !tmo && (rel >= d + 1) && (rel <= d + 1 + bd);
            exp_ctl[0] = !(stop && (rel == h + 1));
            vectors++;
            if ({meas_start, rpt_start, busy} !== exp_ctl) begin
                miscompares++;
                $display("FAIL ctl rel=%0d d=%0d got=%b want=%b",
                         rel, d, {meas_start, rpt_start, busy}, exp_ctl);
            end
            vectors++;
            if ({overrun, timeout_cnt} !== {m_ov, 8'(m_to)}) begin
                miscompares++;
                $display("FAIL ovr_to rel=%0d got=%b/%0d want=%b/%0d",
                         rel, overrun, timeout_cnt, m_ov, m_to);
            end
            if (!(stop && (rel == h + 1))) begin
                want_mode = (rel == nxt) ? m_next : exp_mode;
                vectors++;
                if (rpt_mode !== want_mode) begin
                    miscompares++;
                    $display("FAIL rpt_mode rel=%0d got=%0d want=%0d",
                             rel, rpt_mode, want_mode);
                end
            end
            meas_done = (rel == d);
            rpt_busy  = !tmo && (rel >= d + 1 + bd) && (rel < d + 1 + bd + bl);
            clr_ovr   = (rel == clr_at);
            if (rel == 2) begin
                mode_sel = m_next;
                enable   = en_next;
            end
            if (tmo && (rel == h - 1) && (m_to < 255)) m_to++;
            if (late && (rel == h)) m_ov = 1'b1;
            else if (rel == clr_at) m_ov = 1'b0;
        end
        meas_done = 1'b0;
        rpt_busy  = 1'b0;
        clr_ovr   = 1'b0;
        if (!stop) exp_mode = m_next;
    endtask

    task automatic start_run(input logic [1:0] m);
        enable   = 1'b1;
        mode_sel = m;
        step();
        vectors++;
        if (meas_start !== 1'b1 || rpt_mode !== m) begin
            miscompares++;
            $display("FAIL start got=%b/%0d want=1/%0d", meas_start, rpt_mode, m);
        end
        exp_mode = m;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        vectors++;
        if ({meas_start, rpt_start, busy, rpt_mode, overrun, timeout_cnt} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset got=%b", {meas_start, rpt_start, busy,
                     rpt_mode, overrun, timeout_cnt});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mode_zero();
        enable   = 1'b1;
        mode_sel = 2'b00;
        for (int i = 0; i < 8; i++) begin
            step();
            vectors++;
            if ({busy, meas_start} !== 2'b00) begin
                miscompares++;
                $display("FAIL mode_zero cyc=%0d got=%b want=00", i, {busy, meas_start});
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_nominal();
        start_run(2'b11);
        run_cycle(12, 2, 8, 2'b11, 1'b1, -1);
        for (int i = 0; i < 6; i++) begin
            run_cycle($urandom_range(1, TO_H - 1), $urandom_range(0, 4),
                      $urandom_range(1, 10), 2'($urandom_range(1, 3)), 1'b1, -1);
        end
    endtask

    task automatic test_timeout();
        run_cycle(0, 0, 0, exp_mode, 1'b1, -1);
        for (int i = 0; i < 3; i++) begin
            run_cycle($urandom_range(TO_H, TO_H + 15), 0, 0, exp_mode, 1'b1, -1);
        end
    endtask

    task automatic test_overrun();
        run_cycle(12, 2, 60, exp_mode, 1'b1, -1);
        run_cycle(5, 1, 3, exp_mode, 1'b1, 4);
        run_cycle(12, 2, 60, exp_mode, 1'b1, 12 + 2 + 2 + 60);
        run_cycle(5, 1, 3, exp_mode, 1'b1, 2);
        run_cycle($urandom_range(1, 19), $urandom_range(0, 4),
                  $urandom_range(30, 60), exp_mode, 1'b1, -1);
        run_cycle(6, 0, 2, exp_mode, 1'b1, 3);
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clear got=%b want=0", overrun);
        end
    endtask

    task automatic test_mode_latch();
        run_cycle(8, 1, 4, 2'b10, 1'b1, -1);
        run_cycle(8, 1, 4, 2'b01, 1'b1, -1);
        run_cycle(TO_H - 1, 1, 4, 2'b01, 1'b1, -1);
    endtask

    task automatic test_disable();
        run_cycle(10, 1, 5, exp_mode, 1'b0, -1);
        for (int i = 0; i < 40; i++) begin
            step();
            vectors++;
            if ({meas_start, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL disabled cyc=%0d got=%b want=00", i, {meas_start, busy});
            end
        end
    endtask

    task automatic test_timeout_sat();
        start_run(2'b01);
        for (int i = 0; i < 256; i++) begin
            run_cycle(0, 0, 0, 2'b01, 1'b1, -1);
        end
        vectors++;
        if (timeout_cnt !== 8'hFF) begin
            miscompares++;
            $display("FAIL to_sat got=%0d want=255", timeout_cnt);
        end
        run_cycle(0, 0, 0, 2'b01, 1'b0, -1);
    endtask

    task automatic test_async_reset();
        start_run(2'b11);
        for (int rel = 1; rel <= 13; rel++) begin
            step();
            meas_done = (rel == 12);
        end
        vectors++;
        if (rpt_start !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset rpt_start got=%b want=1", rpt_start);
        end
        enable = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rpt_start, busy, rpt_mode, meas_start} !== 5'd0) begin
            miscompares++;
            $display("FAIL async_reset got=%b want=00000",
                     {rpt_start, busy, rpt_mode, meas_start});
        end
        m_to = 0;
        m_ov = 1'b0;
        exp_mode = 2'b00;
        step();
        rst_n = 1'b1;
        step();
        start_run(2'b11);
        run_cycle(12, 2, 8, 2'b11, 1'b1, -1);
        run_cycle(12, 2, 8, 2'b11, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_mode_zero();
        test_nominal();
        test_timeout();
        test_overrun();
        test_mode_latch();
        test_disable();
        test_timeout_sat();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/meas_scheduler.md
Name: meas_scheduler

Overview:
- Periodic measurement/report sequencer for the frequency meter.
- Each period it starts one measurement on the counting core and waits for completion, with a watchdog timeout.
- It then starts one serial upload frame on the serial transmit controller (start/busy handshake) with the latched report mode.
- It holds until the period elapses, flags overruns and counts timeouts.

Parameters:
- TICK_DIV, 50000: clocks per millisecond tick.
- PERIOD_MS, 1000: measurement period in ms ticks, ARM to ARM; must be >= 1.
- TIMEOUT_MS, 2000: measurement watchdog in ms ticks; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run periodic measurements while high
- mode_sel  in  2  report mode: bit1 = frequency words, bit0 = time words; 0 = nothing to report
- clr_ovr  in  1  single-cycle pulse; clears overrun
- meas_start  out  1  one-clock measurement start pulse
- meas_done  in  1  one-clock pulse from the counting core when results are valid
- rpt_start  out  1  level request to the serial controller
- rpt_busy  in  1  serial controller busy
- rpt_mode  out  2  mode presented to the serial controller; stable from ARM through REPORT_WAIT
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky: a cycle overran its period
- timeout_cnt  out  8  saturating count of measurement timeouts

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; prescaler, period and watchdog counters 0.
- ms tick: prescaler counts 0..TICK_DIV-1 and asserts tick for one clock at TICK_DIV-1. It is cleared on ARM, so ticks are phase-aligned to ARM.
- period_cnt: cleared on ARM; +1 per tick; saturates at PERIOD_MS. elapsed = (period_cnt == PERIOD_MS).
- wd_cnt: cleared on ARM; +1 per tick while in MEASURE only.
- IDLE -> ARM when enable=1 and mode_sel!=0. On that transition, rpt_mode<=mode_sel.
- ARM, one clock: meas_start=1 for exactly this clock (Moore decode of the registered state). Next state MEASURE.
- MEASURE:
  - meas_done=1 -> REPORT_REQ.
  - Else, if tick and wd_cnt+1 == TIMEOUT_MS -> timeout_cnt+1 (saturates at 255) and go to HOLD; no report is sent.
  - meas_done and the timeout tick in the same clock: done wins, no timeout.
- REPORT_REQ: rpt_start=1 (registered), held until rpt_busy=1 is sampled. Then rpt_start<=0 and go to REPORT_WAIT. No timeout in this state.
- REPORT_WAIT: when rpt_busy=0 -> HOLD.
- HOLD:
  - enable=0 or mode_sel==0 -> IDLE next clock; do not wait for the period.
  - Else, if elapsed -> ARM and rpt_mode<=mode_sel.
- Overrun: if elapsed is already true on the first clock in HOLD, overrun<=1 and go directly to ARM.
- Spacing: ARM-to-ARM spacing is exactly PERIOD_MS*TICK_DIV clocks when no overrun occurs.
- enable or mode_sel changing during ARM..REPORT_WAIT is ignored; the in-flight cycle completes.
- clr_ovr clears overrun. If an overrun event occurs in the same clock, set wins.
- meas_done outside MEASURE is ignored. rpt_busy outside REPORT_REQ/REPORT_WAIT is ignored.
- Reset mid-operation drops rpt_start and meas_start immediately (asynchronously); a partial serial frame is the serial controller's concern.

Decomposition:
- Package meas_sched_pkg:
  - state_t enum {IDLE, ARM, MEASURE, REPORT_REQ, REPORT_WAIT, HOLD}
  - MODE_FREQ=2'b10, MODE_TIME=2'b01, MODE_BOTH=2'b11
  - TIMEOUT_SAT=8'hFF
- One sub-module, ms_ticker: prescaler with a sync clear input and a tick output, parameterised by TICK_DIV.
- FSM, period counter and watchdog live in meas_scheduler.

Test Plan (TICK_DIV=4, PERIOD_MS=10, TIMEOUT_MS=5):
- Nominal cycle:
  - Stimulus: enable=1, mode_sel=3; meas_done 12 clocks after meas_start; rpt_busy rises 2 clocks after rpt_start and is held for 8 clocks.
  - Required: rpt_mode=3; rpt_start drops the clock after busy is sampled; two consecutive meas_start pulses exactly 40 clocks apart; overrun=0.
- Timeout:
  - Stimulus: meas_done never asserted.
  - Required: timeout_cnt=1 after 20 clocks in MEASURE; rpt_start never asserted; next meas_start 40 clocks after the first.
  - Also: 256 consecutive timeouts leave timeout_cnt=255.
- Overrun:
  - Stimulus: rpt_busy held for 60 clocks.
  - Required: overrun=1; meas_start 2 clocks after rpt_busy falls.
  - Then clr_ovr pulse -> overrun=0. clr_ovr coincident with a new overrun -> overrun stays 1.
- Disable mid-cycle:
  - Stimulus: enable=0 during MEASURE.
  - Required: the report is still sent; busy=0 the clock after entering HOLD; no further meas_start.
  - Also: mode_sel=0 with enable=1 leaves the block IDLE.
- Mode latch and edge cases:
  - Stimulus: mode_sel changes 2->1 during MEASURE.
  - Required: rpt_mode stays 2 for this report and is 1 at the next ARM.
  - Stimulus: meas_done coincident with the 5th watchdog tick.
  - Required: report is sent, timeout_cnt unchanged.
- Async reset during REPORT_REQ:
  - Required: rpt_start, busy and rpt_mode are all 0 immediately; a restart after reset behaves as in the nominal cycle.
